// File: rtl/led_scan.sv
// led_scan: eight-digit multiplexed seven-segment scanner with frame-synchronous (tear-free) data update.
// Optional inter-digit blanking for anti-ghosting is compiled in by defining LED_SCAN_BLANK_EN.
module led_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        data_vld,
  input  logic [7:0]  dp,
  input  logic [7:0]  dig_en,
  output logic [2:0]  cs_pointer,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  generate
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_scan_div
      $error("led_scan: SCAN_DIV must lie in 2..2^20");
    end
    if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_blank_cyc
      $error("led_scan: BLANK_CYC must lie in 1..255");
    end
  endgenerate

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state, state_nxt;
  logic          run;
  logic [PW-1:0] prescaler;
  logic [31:0]   pend_data, shadow_data, shadow_data_nxt;
  logic [7:0]    pend_dp, shadow_dp, shadow_dp_nxt;
  logic          pend_flag;
  logic          tick, wrap;
  logic [2:0]    ptr_nxt;
  logic [3:0]    digit_nxt;
  logic [7:0]    seg_nxt;
`ifdef LED_SCAN_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
  logic [7:0]    blank_cnt;
`endif

  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    case (d)
      4'h0:    hex_decode = 7'h3F;
      4'h1:    hex_decode = 7'h06;
      4'h2:    hex_decode = 7'h5B;
      4'h3:    hex_decode = 7'h4F;
      4'h4:    hex_decode = 7'h66;
      4'h5:    hex_decode = 7'h6D;
      4'h6:    hex_decode = 7'h7D;
      4'h7:    hex_decode = 7'h07;
      4'h8:    hex_decode = 7'h7F;
      4'h9:    hex_decode = 7'h6F;
      4'hA:    hex_decode = 7'h77;
      4'hB:    hex_decode = 7'h7C;
      4'hC:    hex_decode = 7'h39;
      4'hD:    hex_decode = 7'h5E;
      4'hE:    hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // run holds the prescaler for the first edge after reset so digit 0 dwells a full SCAN_DIV cycles.
  assign tick    = run && (state == SHOW) && (prescaler == PRE_LAST);
  assign wrap    = tick && (cs_pointer == 3'd7);
  assign ptr_nxt = tick ? cs_pointer + 3'd1 : cs_pointer;

  always_comb begin
    state_nxt = state;
`ifdef LED_SCAN_BLANK_EN
    if (tick)
      state_nxt = BLANK;
    else if (state == BLANK && blank_cnt == BLANK_LAST)
      state_nxt = SHOW;
`else
    state_nxt = SHOW;
`endif
  end

  // Pending data lands at the wrap edge; a strobe in the frame_done cycle goes straight to shadow.
  always_comb begin
    shadow_data_nxt = shadow_data;
    shadow_dp_nxt   = shadow_dp;
    if (frame_done && data_vld) begin
      shadow_data_nxt = data;
      shadow_dp_nxt   = dp;
    end else if (wrap && pend_flag) begin
      shadow_data_nxt = pend_data;
      shadow_dp_nxt   = pend_dp;
    end
  end

  assign digit_nxt = shadow_data_nxt[{ptr_nxt, 2'b00} +: 4];
  assign seg_nxt   = (state_nxt == SHOW && dig_en[ptr_nxt]) ?
                     {shadow_dp_nxt[ptr_nxt], hex_decode(digit_nxt)} : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHOW;
      run         <= 1'b0;
      prescaler   <= '0;
      cs_pointer  <= 3'd0;
      seg         <= 8'h00;
      frame_done  <= 1'b0;
      pend_data   <= 32'h0;
      pend_dp     <= 8'h00;
      pend_flag   <= 1'b0;
      shadow_data <= 32'h0;
      shadow_dp   <= 8'h00;
`ifdef LED_SCAN_BLANK_EN
      blank_cnt   <= 8'd0;
`endif
    end else begin
      run         <= 1'b1;
      state       <= state_nxt;
      cs_pointer  <= ptr_nxt;
      frame_done  <= wrap;
      seg         <= seg_nxt;
      shadow_data <= shadow_data_nxt;
      shadow_dp   <= shadow_dp_nxt;

      if (data_vld && !frame_done) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_flag <= 1'b1;
      end else if (data_vld || wrap) begin
        pend_flag <= 1'b0;
      end

      if (tick)
        prescaler <= '0;
      else if (run && state == SHOW)
        prescaler <= prescaler + PW'(1);

`ifdef LED_SCAN_BLANK_EN
      if (state == BLANK)
        blank_cnt <= (blank_cnt == BLANK_LAST) ? 8'd0 : blank_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_led_scan.sv
// tb_led_scan: directed bench for led_scan (SCAN_DIV=4, BLANK_CYC=2) with a slot-timeline reference model.
`timescale 1ns/1ps
module tb_led_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
`ifdef LED_SCAN_BLANK_EN
  localparam int BLANK_LEN = BLANK_CYC;
`else
  localparam int BLANK_LEN = 0;
`endif
  localparam int PERIOD = SCAN_DIV + BLANK_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data = 32'h0;
  logic        data_vld = 1'b0;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  dig_en = 8'hFF;
  logic [2:0]  cs_pointer;
  logic [7:0]  seg;
  logic        frame_done;

  led_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(data_vld), .dp(dp),
    .dig_en(dig_en), .cs_pointer(cs_pointer), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: wait expired at %0t", name, $time);
  endtask

  // Reference model: the timeline after release is a sequence of slots. Slot 0 lasts SCAN_DIV edges,
  // every later slot lasts PERIOD edges, the first BLANK_LEN of which are dark.
  logic [6:0]  hexTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          edgeCount, mU, mSlot, mPhase, mIdx;
  bit          mWrap, mBlank, mPrevFd;
  logic [31:0] mShownData;
  logic [7:0]  mShownDp;
  logic [39:0] mPendQ [$];
  logic [39:0] mEntry;
  logic [2:0]  mPtr;
  logic [7:0]  mSeg;
  logic        mFrameDone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCount = 0; mShownData = 32'h0; mShownDp = 8'h00; mPendQ.delete();
      mPtr = 3'd0; mSeg = 8'h00; mFrameDone = 1'b0;
    end else begin
      edgeCount++;
      mPrevFd = mFrameDone;
      mU = edgeCount - 1 - SCAN_DIV;
      if (mU < 0) begin
        mSlot = 0; mPhase = 0; mWrap = 0; mBlank = 0;
      end else begin
        mSlot  = mU / PERIOD + 1;
        mPhase = mU % PERIOD;
        mBlank = (mPhase < BLANK_LEN);
        mWrap  = (mPhase == 0) && (mSlot % 8 == 0);
      end
      if (data_vld && mPrevFd) begin
        mShownData = data; mShownDp = dp; mPendQ.delete();
      end else begin
        if (mWrap && mPendQ.size() > 0) begin
          mEntry = mPendQ[$];
          {mShownData, mShownDp} = mEntry;
          mPendQ.delete();
        end
        if (data_vld) begin
          mPendQ.delete();
          mPendQ.push_back({data, dp});
        end
      end
      mPtr = 3'(mSlot % 8);
      mIdx = mSlot % 8;
      mFrameDone = mWrap;
      if (mBlank || !dig_en[mIdx]) mSeg = 8'h00;
      else mSeg = {mShownDp[mIdx], hexTable[mShownData[mIdx*4 +: 4]]};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_ptr", cs_pointer, 0);
      checkOutput("reset_seg", seg, 0);
      checkOutput("reset_fd", frame_done, 0);
    end else begin
      checkOutput("model_ptr", cs_pointer, mPtr);
      checkOutput("model_seg", seg, mSeg);
      checkOutput("model_fd", frame_done, mFrameDone);
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] p, input logic [7:0] en);
    #1;
    data = d;
    dp = p;
    dig_en = en;
  endtask

  task automatic pulseValid(input logic [31:0] d, input logic [7:0] p);
    #1;
    data = d;
    dp = p;
    data_vld = 1'b1;
    @(negedge clk);
    #1 data_vld = 1'b0;
  endtask

  task automatic waitPointer(input logic [2:0] p);
    logic [2:0] prev;
    prev = cs_pointer;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cs_pointer == p && prev != p) return;
      prev = cs_pointer;
    end
    reportTimeout("wait_pointer");
  endtask

  task automatic waitSlotEnd(input logic [2:0] p);
    waitPointer(p);
    repeat (PERIOD - 1) @(negedge clk);
  endtask

  task automatic waitFrameDone();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
    end
    reportTimeout("wait_frame_done");
  endtask

  logic [7:0] frameSeg [8];
  logic [7:0] expSeg [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
  int gap;

  initial begin
    #1 rst_n = 1'b0;
    #2 checkOutput("async_reset_seg", seg, 8'h00);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (SCAN_DIV) @(posedge clk);
    #1 checkOutput("first_dwell_ptr", cs_pointer, 3'd0);
    checkOutput("first_dwell_seg", seg, 8'h3F);
    @(posedge clk);
    #1 checkOutput("first_advance_ptr", cs_pointer, 3'd1);

    waitFrameDone();
    gap = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      gap++;
      if (frame_done === 1'b1) break;
    end
`ifdef LED_SCAN_BLANK_EN
    checkOutput("frame_period", gap, 48);
`else
    checkOutput("frame_period", gap, 32);
`endif
    repeat (3) @(negedge clk);
    checkOutput("zero_data_seg", seg, 8'h3F);

    waitPointer(3'd3);
    pulseValid(32'h76543210, 8'h00);
    waitSlotEnd(3'd7);
    checkOutput("held_until_frame_end", seg, 8'h3F);
    for (int s = 0; s < 8; s++) begin
      waitSlotEnd(3'(s));
      frameSeg[s] = seg;
    end
    for (int s = 0; s < 8; s++) checkOutput($sformatf("new_frame_slot%0d", s), frameSeg[s], expSeg[s]);

    waitFrameDone();
    pulseValid(32'hFFFFFFFF, 8'h00);
    waitSlotEnd(3'd1);
    checkOutput("boundary_load_slot1", seg, 8'h71);
    waitSlotEnd(3'd3);
    checkOutput("boundary_load_slot3", seg, 8'h71);

    pulseValid(32'hFFFFFFFF, 8'h01);
    applyStimulus(32'hFFFFFFFF, 8'h01, 8'hFE);
    waitPointer(3'd0);
    checkOutput("disabled_slot0_first", seg, 8'h00);
    repeat (PERIOD - 2) @(negedge clk);
    checkOutput("disabled_slot0_mid", seg, 8'h00);
    applyStimulus(32'hFFFFFFFF, 8'h01, 8'hFF);
    @(negedge clk);
    checkOutput("enable_with_dp", seg, 8'hF1);
    waitSlotEnd(3'd1);
    checkOutput("slot1_unaffected", seg, 8'h71);

    waitPointer(3'd5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput("midwell_reset_ptr", cs_pointer, 3'd0);
    checkOutput("midwell_reset_seg", seg, 8'h00);
    checkOutput("midwell_reset_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (SCAN_DIV) @(posedge clk);
    #1 checkOutput("rerelease_dwell_ptr", cs_pointer, 3'd0);
    @(posedge clk);
    #1 checkOutput("rerelease_advance_ptr", cs_pointer, 3'd1);

    waitPointer(3'd2);
`ifdef LED_SCAN_BLANK_EN
    checkOutput("blank_phase0", seg, 8'h00);
    @(negedge clk);
    checkOutput("blank_phase1", seg, 8'h00);
`else
    checkOutput("noblank_phase0", seg, 8'h3F);
    @(negedge clk);
    checkOutput("noblank_phase1", seg, 8'h3F);
`endif
    @(negedge clk);
    checkOutput("show_phase2", seg, 8'h3F);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_scan.md
LED_SCAN -- requirements
Module: led_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit is shown; legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_CYC, default 16: blanking cycles between digits; legal range 1..255; used only with LED_SCAN_BLANK_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data, input, 32 bits: eight 4-bit hex digits; digit k = data[4k+3:4k].
REQ-006 The block SHALL have port data_vld, input, 1 bit: single-cycle strobe that captures data and dp.
REQ-007 The block SHALL have port dp, input, 8 bits: decimal-point request per digit, captured with data.
REQ-008 The block SHALL have port dig_en, input, 8 bits: live (uncaptured) per-digit enable; 0 blanks that digit.
REQ-009 The block SHALL have port cs_pointer, output, 3 bits: index of the active digit; feeds the downstream one-hot chip-select decoder.
REQ-010 The block SHALL have port seg, output, 8 bits: registered, active-high; bit0..bit6 = segments a..g, bit7 = dp.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at every frame wrap.

Function
REQ-012 The block SHALL use a prescaler counter of width clog2(SCAN_DIV) that counts 0..SCAN_DIV-1 while in state SHOW.
REQ-013 On the cycle the prescaler equals SCAN_DIV-1, the block SHALL advance cs_pointer by 1 modulo 8 and reset the prescaler to 0.
REQ-014 The pointer wrap 7->0 SHALL be the frame boundary; frame_done SHALL be 1 in exactly the cycle cs_pointer first reads 0.
REQ-015 A data_vld pulse SHALL load data and dp into a pending register and set a pending flag.
REQ-016 At a frame boundary with the pending flag set, the block SHALL copy pending to the shadow register and clear the flag, so the display never tears mid-frame.
REQ-017 data_vld coinciding with a frame boundary SHALL load the new data and dp directly into shadow and leave the pending flag clear.
REQ-018 Back-to-back data_vld pulses within one frame SHALL leave only the last value for the next boundary.
REQ-019 seg SHALL equal hex_decode(shadow digit[cs_pointer]) with bit7 = shadow_dp[cs_pointer]; it SHALL update in the same cycle as cs_pointer, with no skew between them.
REQ-020 Hex decode SHALL map 0..F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-021 When dig_en[cs_pointer]=0, seg SHALL be 00, and the scan timing SHALL be unchanged (the disabled slot is still dwelt).
REQ-022 A change on dig_en SHALL be reflected on seg within 1 cycle.
REQ-023 The state machine SHALL have states SHOW and BLANK; BLANK is reachable only with LED_SCAN_BLANK_EN defined.

Reset
REQ-024 While rst_n=0, the block SHALL hold: cs_pointer=0, seg=00, frame_done=0, prescaler=0, state=SHOW, pending and shadow registers all zero, pending flag=0.
REQ-025 Reset assertion mid-dwell SHALL take effect immediately, without waiting for a clock edge.
REQ-026 After release, the first pointer advance SHALL occur SCAN_DIV cycles after the first rising edge.
REQ-027 After release, no frame_done SHALL be generated until the first 7->0 wrap.

Configuration
REQ-028 With LED_SCAN_BLANK_EN defined, the prescaler terminal count SHALL move the block to BLANK and advance cs_pointer in that same cycle.
REQ-029 With LED_SCAN_BLANK_EN defined, BLANK SHALL force seg=00 for BLANK_CYC cycles, then return to SHOW with the prescaler at 0 (anti-ghosting).
REQ-030 With LED_SCAN_BLANK_EN defined, the digit period SHALL be SCAN_DIV+BLANK_CYC cycles.
REQ-031 Without LED_SCAN_BLANK_EN, the block SHALL contain no BLANK logic and the digit period SHALL be exactly SCAN_DIV cycles.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-032 The bench SHALL cover: reset release with data=0 -> cs_pointer steps 0,1,2...7,0 every 4 cycles; frame_done pulses once per 32 cycles; seg=3F in every slot with dig_en=FF.
REQ-033 The bench SHALL cover: data=76543210, data_vld pulsed at pointer=3 -> seg holds 3F through pointer 7, then shows 3F,06,5B,4F,66,6D,7D,07 from the next frame.
REQ-034 The bench SHALL cover: data_vld in the exact frame_done cycle with data=FFFFFFFF -> seg=71 in that same frame.
REQ-035 The bench SHALL cover: dig_en=FE, dp=01 -> slot 0 seg=00; other slots unaffected; timing unchanged.
REQ-036 The bench SHALL cover: rst_n pulled low at pointer=5 mid-dwell -> outputs clear immediately (cs_pointer=0, seg=00); first advance comes 4 cycles after release.
REQ-037 The bench SHALL cover, with LED_SCAN_BLANK_EN: the digit period is 6 cycles and seg=00 for exactly 2 cycles after each pointer change.
